// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Declarations shared by the shift-register family: the load-and-shift
// transmitters and the shift_rx_word receiver.
//
//   shift_state_e  : two-state frame controller (IDLE, COLLECT)
//   DEFAULT_WIDTH  : default bits per serial frame
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } shift_state_e;

endpackage : shift_pkg

// File: rtl/shift_rx_outreg.sv
// ---------------------------------------------------------------------------
// shift_rx_outreg
// Single-entry valid/ready output register for the serial receiver, with a
// sticky overrun flag for words that arrive while the slot is still full.
//
// Ports:
//   Clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   load_i     a completed word is offered this cycle
//   word_i     the completed word
//   ready_i    consumer accepts data_o this cycle
//   clr_err_i  synchronous clear of the overrun flag
//   data_o     last accepted word
//   valid_o    data_o holds an unconsumed word
//   overrun_o  sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module shift_rx_outreg
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    // Next-state for the slot. A word may be loaded when the slot is empty
    // or is being drained on this very edge; otherwise the word is dropped
    // and the stored data is left untouched. A new overrun beats clr_err.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~clr_err_i;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output slot registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule : shift_rx_outreg

// File: rtl/shift_rx_word.sv
// ---------------------------------------------------------------------------
// shift_rx_word
// Serial-in/parallel-out receiver for the LSB-first stream produced by the
// load-and-shift transmitters. Collects WIDTH bits into a word, presents it
// on a valid/ready output, and flags frame restarts and overruns.
//
// Ports:
//   Clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   s_valid    s_bit is meaningful this cycle
//   s_bit      serial data bit, LSB first
//   s_start    with s_valid: this bit is bit 0 of a new frame
//   out_ready  consumer accepts out_data this cycle
//   clr_err    synchronous clear of the sticky error flags
//   out_data   last completed word
//   out_valid  out_data holds an unconsumed word
//   busy       a frame is partially received
//   overrun    sticky: a completed word was dropped
//   frame_err  sticky: a frame was restarted before completion
// ---------------------------------------------------------------------------
module shift_rx_word
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_start,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    shift_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             frameErr_q, frameErr_d;
    logic             wordDone;
    logic [WIDTH-1:0] shifted;

    // Only the upper WIDTH-1 bits of the shift register are stored: the bit
    // that would drop into position 0 is needed only at completion, where
    // it is taken straight from the shifted word.
    logic [WIDTH-2:0] shreg_q, shreg_d;

    assign shifted = {s_bit, shreg_q};

    // Frame controller: a start bit always opens a fresh frame (flagging a
    // restart if one was in progress); plain bits are only accepted inside
    // a frame, and the WIDTH-th bit hands the word to the output slot.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        frameErr_d = frameErr_q & ~clr_err;
        wordDone   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid && s_start) begin
                    shreg_d = shifted[WIDTH-1:1];
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (s_valid) begin
                    shreg_d = shifted[WIDTH-1:1];
                    if (s_start) begin
                        frameErr_d = 1'b1;
                        cnt_d      = CW'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        wordDone = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller, shift register and frame-error registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            frameErr_q <= frameErr_d;
        end
    end

    shift_rx_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .Clk       (Clk),
        .reset     (reset),
        .load_i    (wordDone),
        .word_i    (shifted),
        .ready_i   (out_ready),
        .clr_err_i (clr_err),
        .data_o    (out_data),
        .valid_o   (out_valid),
        .overrun_o (overrun)
    );

    assign busy      = (state_q == COLLECT);
    assign frame_err = frameErr_q;

endmodule : shift_rx_word

// File: tb/tb_shift_rx_word.sv
// ---------------------------------------------------------------------------
// tb_shift_rx_word
// Self-checking bench for shift_rx_word (WIDTH=8): a table of directed
// vectors, hand-written multi-cycle sequences, and a randomized phase
// compared against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_shift_rx_word;

    localparam int W = 8;

    logic         Clk;
    logic         reset;
    logic         s_valid, s_bit, s_start, out_ready, clr_err;
    logic [W-1:0] out_data;
    logic         out_valid, busy, overrun, frame_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, kept at frame level: a bit count and a word
    // assembled by bit position.
    int           mCount;
    logic [W-1:0] mWord;
    logic         mBusy, mOutValid, mOverrun, mFrameErr;
    logic [W-1:0] mOutData;

    typedef struct {
        logic         v, b, st, rdy, clr;
        logic [W-1:0] expData;
        logic         expValid, expBusy, expOv, expFe;
    } vec_t;

    vec_t vecs[9];

    shift_rx_word #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .s_start   (s_start),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model reset, mirroring the effect of an asynchronous reset.
    task automatic modelReset();
        mCount    = 0;
        mWord     = '0;
        mBusy     = 1'b0;
        mOutValid = 1'b0;
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
        mOutData  = '0;
    endtask

    // Model one clock edge from the receiver's frame rules.
    task automatic modelStep(input logic v, b, st, rdy, clr);
        logic         done  = 1'b0;
        logic         setOv = 1'b0;
        logic         setFe = 1'b0;
        logic [W-1:0] doneWord = '0;
        if (v) begin
            if (st) begin
                if (mBusy) setFe = 1'b1;
                mBusy    = 1'b1;
                mWord    = '0;
                mWord[0] = b;
                mCount   = 1;
            end else if (mBusy) begin
                mWord[mCount] = b;
                mCount++;
                if (mCount == W) begin
                    done     = 1'b1;
                    doneWord = mWord;
                    mBusy    = 1'b0;
                    mCount   = 0;
                end
            end
        end
        if (done) begin
            if (mOutValid && !rdy) setOv = 1'b1;
            else begin
                mOutData  = doneWord;
                mOutValid = 1'b1;
            end
        end else if (mOutValid && rdy) begin
            mOutValid = 1'b0;
        end
        mOverrun  = setOv ? 1'b1 : (clr ? 1'b0 : mOverrun);
        mFrameErr = setFe ? 1'b1 : (clr ? 1'b0 : mFrameErr);
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit
    // after the active edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic v, b, st, rdy, clr);
        s_valid   = v;
        s_bit     = b;
        s_start   = st;
        out_ready = rdy;
        clr_err   = clr;
        modelStep(v, b, st, rdy, clr);
        @(posedge Clk);
        #1;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] expData,
                               input logic expValid, expBusy, expOv, expFe);
        compareField(name, "out_data",  32'(out_data),  32'(expData));
        compareField(name, "out_valid", 32'(out_valid), 32'(expValid));
        compareField(name, "busy",      32'(busy),      32'(expBusy));
        compareField(name, "overrun",   32'(overrun),   32'(expOv));
        compareField(name, "frame_err", 32'(frame_err), 32'(expFe));
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mOutData, mOutValid, mBusy, mOverrun, mFrameErr);
    endtask

    task automatic sendWord(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++)
            applyStimulus(1'b1, w[i], i == 0, rdy, 1'b0);
    endtask

    initial begin
        // Basic receive of 0xA5 with out_ready held high.
        vecs[0] = '{1, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[1] = '{1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[2] = '{1, 1, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[3] = '{1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[4] = '{1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[5] = '{1, 1, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[6] = '{1, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vecs[7] = '{1, 1, 0, 1, 0, 8'hA5, 1, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 1, 0, 8'hA5, 0, 0, 0, 0};

        reset = 1'b0;
        s_valid = 0; s_bit = 0; s_start = 0; out_ready = 0; clr_err = 0;
        modelReset();
        #12;
        checkOutput("reset", 8'h00, 0, 0, 0, 0);
        @(posedge Clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].v, vecs[i].b, vecs[i].st, vecs[i].rdy, vecs[i].clr);
            checkOutput($sformatf("basic[%0d]", i), vecs[i].expData, vecs[i].expValid,
                        vecs[i].expBusy, vecs[i].expOv, vecs[i].expFe);
        end

        // Gapped stream: 0x3C with three idle cycles after bit 3.
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, 8'h3C >> i, i == 0, 1'b1, 1'b0);
            if (i == 3) begin
                for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
                checkOutput("gap_hold", 8'hA5, 0, 1, 0, 0);
            end
        end
        checkOutput("gapped", 8'h3C, 1, 0, 0, 0);

        // Restart mid-frame, then clear the flag.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
        sendWord(8'h81, 1'b1);
        checkOutput("restart", 8'h81, 1, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("restart_clr", 8'h81, 0, 0, 0, 0);

        // Backpressure and overrun.
        sendWord(8'h12, 1'b0);
        checkOutput("bp_first", 8'h12, 1, 0, 0, 0);
        sendWord(8'h34, 1'b0);
        checkOutput("overrun", 8'h12, 1, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain", 8'h12, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ov_clr", 8'h12, 0, 0, 0, 0);

        // Consume and complete on the same edge.
        sendWord(8'h55, 1'b0);
        checkOutput("hold55", 8'h55, 1, 0, 0, 0);
        for (int i = 0; i < W; i++)
            applyStimulus(1'b1, 8'hAA >> i, i == 0, i == W - 1, 1'b0);
        checkOutput("simul", 8'hAA, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("simul_drain", 8'hAA, 0, 0, 0, 0);

        // Asynchronous reset mid-frame with a pending word.
        sendWord(8'h77, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
        checkOutput("pre_reset", 8'h77, 1, 1, 0, 0);
        s_valid = 0; s_start = 0;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 0, 0, 0, 0);
        modelReset();
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("post_reset", 8'h00, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 1),
                          $urandom_range(0, 29) == 0);
            checkModel($sformatf("rand[%0d]", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_shift_rx_word

// File: doc/shift_rx_word.md
Name: shift_rx_word

Overview:
- Serial-in/parallel-out receiver. It is the receiving end of the right-shifting, LSB-first serial stream produced by the team's load-and-shift registers.
- It collects WIDTH serial bits into a word and presents the word on a valid/ready parallel output.
- It flags frame restarts and overruns.
- It sits between the shift-out datapath and any parallel consumer (register file, display logic).

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width. Derived; never overridden.

Ports:
- Clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- s_valid  input  1  s_bit is meaningful this cycle
- s_bit  input  1  serial data bit, LSB of the word first
- s_start  input  1  qualifies s_valid: this bit is bit 0 of a new frame
- out_ready  input  1  consumer accepts out_data this cycle
- clr_err  input  1  synchronous clear of the sticky error flags
- out_data  output  WIDTH  last completed word
- out_valid  output  1  out_data holds an unconsumed word
- busy  output  1  a frame is partially received
- overrun  output  1  sticky: a completed word was dropped
- frame_err  output  1  sticky: a frame was restarted before completion

Behaviour:
- Reset is asynchronous on the negedge of reset. It forces:
  - state to IDLE, shreg=0, cnt=0
  - out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0
- Reset mid-frame discards the partial word. A pending output word is lost.
- States are IDLE and COLLECT. busy=1 exactly when state is COLLECT.
- A bit is accepted in any cycle with s_valid=1 that is not ignored under the rules below.
- Shift rule for each accepted bit: shreg <= {s_bit, shreg[WIDTH-1:1]}, i.e. fill from the MSB and shift toward the LSB, so bit 0 ends up in shreg[0] after WIDTH bits. cnt increments by 1.
- IDLE:
  - s_valid & s_start: shreg receives the first bit, cnt=1, go to COLLECT.
  - s_valid & !s_start: bit ignored, stay in IDLE.
  - Special case WIDTH==1 is not supported; see the parameter range.
- COLLECT:
  - s_valid & !s_start: accept the bit.
  - If it is the WIDTH-th bit (cnt==WIDTH-1 before the edge):
    - the completed word {s_bit, shreg[WIDTH-1:1]} is offered to the output register
    - cnt returns to 0 and state returns to IDLE.
  - s_valid & s_start: restart the frame. frame_err<=1, the partial word is discarded, this bit becomes bit 0, cnt=1, stay in COLLECT.
  - s_valid=0: hold all state. There is no timeout.
- Output register (single entry):
  - Completion with out_valid=0: out_data<=word, out_valid<=1 on the same edge. out_valid is therefore visible in the cycle after the last bit is sampled (latency 1).
  - out_valid & out_ready with no completion: out_valid<=0; out_data holds its value.
  - Completion and out_valid & out_ready on the same edge: the new word is loaded and out_valid stays 1. This is not an overrun.
  - Completion with out_valid & !out_ready: the new word is dropped, out_data is unchanged, overrun<=1.
- out_data must not change while out_valid=1 && !out_ready.
- Sticky flags:
  - overrun and frame_err clear only on clr_err=1 or reset.
  - If clr_err and a new error event occur on the same edge, the set wins.
- s_start without s_valid has no effect.

Decomposition:
- Shared package shift_pkg holds:
  - the state enum (IDLE, COLLECT), also reused by the shift transmitters
  - the localparam DEFAULT_WIDTH=8.
- One natural sub-module, shift_rx_outreg: the single-entry valid/ready output register with overrun detection.
- The FSM, shift register and counter stay in the top module.

Test Plan:
1. Basic receive: reset low, then high. Send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1), one per cycle, s_start on the first bit, out_ready=1 → out_data=0xA5 and out_valid=1 in the cycle after bit 8. busy is high for 7 cycles and low after completion.
2. Gapped stream: send 0x3C with s_valid dropped for 3 cycles between bits 4 and 5 → out_data=0x3C. No flags set.
3. Restart: send 3 bits of 0xFF, then assert s_start with the first bit of 0x81 and send the full word → frame_err=1, out_data=0x81. clr_err for one cycle → frame_err=0.
4. Backpressure and overrun: out_ready=0; receive 0x12, then 0x34 → out_data stays 0x12, overrun=1. Raise out_ready → out_valid falls the next cycle.
5. Simultaneous: hold the 0x55 word unread. Assert out_ready on the exact edge where 0xAA completes → out_data=0xAA, out_valid stays 1, overrun=0.
6. Async reset mid-frame: after 5 bits, pulse reset low between clock edges → all outputs 0 immediately. Bits sent after reset without s_start are ignored (busy stays 0).
